instr_encoder: RTL and testbench

- Inverse of the core's immediate generator: packs opcode, register fields, funct3 and a 32-bit immediate into a RISC-V RV32I instruction word.
- Two-stage valid/ready pipeline with a byte-address counter.
- Used by the boot/test loader to program instruction memory.
- Catches immediates the selected format cannot represent.

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 144 ++++++++++++++
 tb/tb_instr_encoder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Bundle of the encoder's capture-side and output-side handshake signals.
// The master modport is the loader/bench side; the slave modport is the encoder.
interface instr_encoder_if #(
  parameter int K  = 3,
  parameter int AW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  imm_sel;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [31:0]   imm;
  logic          clear_addr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic [7:0]    err_cnt;

  modport master (
    output in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, imm, clear_addr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, imm, clear_addr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: captures fields + immediate, emits a packed word with its imem address.
// Define IMMENC_RANGE_CHECK_EN to flag immediates the selected format cannot represent.
module instr_encoder #(
  parameter int            K         = 3,
  parameter int            AW        = 12,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  localparam logic [K-1:0] SEL_I = K'(0);
  localparam logic [K-1:0] SEL_S = K'(1);
  localparam logic [K-1:0] SEL_B = K'(2);
  localparam logic [K-1:0] SEL_U = K'(3);
  localparam logic [K-1:0] SEL_J = K'(4);

  // Handshake: a word moves across an interface on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and a presented output word is held until taken.
  logic          s1_valid_q, s1_valid_d;
  logic [K-1:0]  s1_sel_q;
  logic [6:0]    s1_op_q;
  logic [4:0]    s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]    s1_f3_q;
  logic [31:0]   s1_imm_q;

  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_instr_q;
  logic          out_err_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    errcnt_q, errcnt_d;

  logic          s1_adv, in_ready, capture, load, handshake;
  logic [31:0]   enc_instr;
  logic          sel_bad, range_bad, enc_err;

  assign s1_adv    = !out_valid_q | bus.out_ready;
  assign in_ready  = !rst & (!s1_valid_q | s1_adv);
  assign capture   = bus.in_valid & in_ready;
  assign load      = s1_valid_q & s1_adv;
  assign handshake = out_valid_q & bus.out_ready;

  assign s1_valid_d  = in_ready ? bus.in_valid : s1_valid_q;
  assign out_valid_d = s1_adv ? s1_valid_q : out_valid_q;

  always_comb begin
    enc_instr = 32'h0000_0013;
    sel_bad   = 1'b0;
    case (s1_sel_q)
      SEL_I: enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      SEL_S: enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      SEL_B: enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      SEL_U: enc_instr = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      SEL_J: enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                          s1_rd_q, s1_op_q};
      default: sel_bad = 1'b1;
    endcase
  end

`ifdef IMMENC_RANGE_CHECK_EN
  // A signed value fits n bits when every bit from n-1 upward equals the sign.
  logic fit12, fit13, fit21;
  assign fit12 = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
  assign fit13 = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
  assign fit21 = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

  always_comb begin
    range_bad = 1'b0;
    case (s1_sel_q)
      SEL_I, SEL_S: range_bad = ~fit12;
      SEL_B:        range_bad = ~fit13 | s1_imm_q[0];
      SEL_U:        range_bad = |s1_imm_q[11:0];
      SEL_J:        range_bad = ~fit21 | s1_imm_q[0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign enc_err = sel_bad | range_bad;

  // clear_addr wins over a same-cycle handshake so the next word starts at BASE_ADDR.
  always_comb begin
    addr_d = addr_q;
    if (bus.clear_addr)  addr_d = BASE_ADDR;
    else if (handshake)  addr_d = addr_q + AW'(4);
  end

  always_comb begin
    errcnt_d = errcnt_q;
    if (handshake && out_err_q && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_f3_q    <= '0;
      s1_imm_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (capture) begin
        s1_sel_q <= bus.imm_sel;
        s1_op_q  <= bus.opcode;
        s1_rd_q  <= bus.rd;
        s1_rs1_q <= bus.rs1;
        s1_rs2_q <= bus.rs2;
        s1_f3_q  <= bus.funct3;
        s1_imm_q <= bus.imm;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      addr_q      <= BASE_ADDR;
      errcnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      errcnt_q    <= errcnt_d;
      if (load) begin
        out_instr_q <= enc_instr;
        out_err_q   <= enc_err;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_cnt   = errcnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a word-level pipeline model checked every cycle plus literal vectors.
// A second instance with a 4-bit address counter shares the stimulus to exercise wrap-around.
module tb_instr_encoder;
  localparam int K   = 3;
  localparam int AW  = 12;
  localparam int AWS = 4;
`ifdef IMMENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.K(K), .AW(AW))  bm ();
  instr_encoder_if #(.K(K), .AW(AWS)) bs ();

  instr_encoder #(.K(K), .AW(AW),  .BASE_ADDR(12'h000)) dut   (.clk(clk), .rst(rst), .bus(bm.slave));
  instr_encoder #(.K(K), .AW(AWS), .BASE_ADDR(4'h0))    dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

  assign bs.in_valid   = bm.in_valid;
  assign bs.imm_sel    = bm.imm_sel;
  assign bs.opcode     = bm.opcode;
  assign bs.rd         = bm.rd;
  assign bs.rs1        = bm.rs1;
  assign bs.rs2        = bm.rs2;
  assign bs.funct3     = bm.funct3;
  assign bs.imm        = bm.imm;
  assign bs.clear_addr = bm.clear_addr;
  assign bs.out_ready  = bm.out_ready;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoding straight from the format tables and signed ranges.
  function automatic void model_enc(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd_v,
                                    input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                    input logic [2:0] f3, input logic [31:0] iv,
                                    output logic [31:0] w, output logic e);
    longint v;
    logic   rng;
    v   = longint'($signed(iv));
    w   = 32'h0;
    rng = 1'b0;
    w[6:0] = op;
    case (sel)
      3'd0: begin
        w[31:20] = iv[11:0]; w[19:15] = rs1_v; w[14:12] = f3; w[11:7] = rd_v;
        rng = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        w[31:25] = iv[11:5]; w[24:20] = rs2_v; w[19:15] = rs1_v; w[14:12] = f3; w[11:7] = iv[4:0];
        rng = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w[31] = iv[12]; w[30:25] = iv[10:5]; w[24:20] = rs2_v; w[19:15] = rs1_v; w[14:12] = f3;
        w[11:8] = iv[4:1]; w[7] = iv[11];
        rng = (v < -4096) || (v > 4094) || iv[0];
      end
      3'd3: begin
        w[31:12] = iv[31:12]; w[11:7] = rd_v;
        rng = (iv[11:0] != 12'h0);
      end
      3'd4: begin
        w[31] = iv[20]; w[30:21] = iv[10:1]; w[20] = iv[11]; w[19:12] = iv[19:12]; w[11:7] = rd_v;
        rng = (v < -1048576) || (v > 1048574) || iv[0];
      end
      default: w = 32'h0000_0013;
    endcase
    e = (sel > 3'd4) || (RANGE_EN && rng);
  endfunction

  typedef struct { logic [31:0] instr; logic err; int age; } mword_t;
  mword_t mq[$];
  int maddr = 0, maddr_s = 0, mcnt = 0, acc_count = 0;
  logic [31:0]    hs_instr[$];
  logic           hs_err[$];
  logic [AW-1:0]  hs_addr[$];
  logic [AWS-1:0] hs_addr_s[$];

  // Compare process: words in flight form a queue; a word reaches the output two edges
  // after capture, and at most two words can be in flight.
  always @(negedge clk) begin
    logic        exp_ov, exp_ir, hs, acc, e;
    logic [31:0] w;
    if (rst) begin
      mq.delete();
      maddr = 0; maddr_s = 0; mcnt = 0;
      chk("rst_out_valid", {31'b0, bm.out_valid}, 32'h0);
      chk("rst_in_ready",  {31'b0, bm.in_ready},  32'h0);
      chk("rst_out_instr", bm.out_instr, 32'h0);
      chk("rst_out_err",   {31'b0, bm.out_err},   32'h0);
      chk("rst_err_cnt",   {24'b0, bm.err_cnt},   32'h0);
      chk("rst_out_addr",  {20'b0, bm.out_addr},  32'h0);
      chk("rst_s_valid",   {31'b0, bs.out_valid}, 32'h0);
    end else begin
      exp_ov = (mq.size() > 0) && (mq[0].age >= 2);
      exp_ir = (mq.size() < 2) || bm.out_ready;
      chk("out_valid", {31'b0, bm.out_valid}, {31'b0, exp_ov});
      chk("in_ready",  {31'b0, bm.in_ready},  {31'b0, exp_ir});
      chk("out_addr",  {20'b0, bm.out_addr},  32'(maddr));
      chk("err_cnt",   {24'b0, bm.err_cnt},   32'(mcnt));
      chk("s_out_valid", {31'b0, bs.out_valid}, {31'b0, exp_ov});
      chk("s_out_addr",  {28'b0, bs.out_addr},  32'(maddr_s));
      if (exp_ov) begin
        chk("out_instr",   bm.out_instr, mq[0].instr);
        chk("out_err",     {31'b0, bm.out_err}, {31'b0, mq[0].err});
        chk("s_out_instr", bs.out_instr, mq[0].instr);
      end
      hs  = exp_ov && bm.out_ready;
      acc = bm.in_valid && exp_ir;
      if (hs) begin
        hs_instr.push_back(bm.out_instr);
        hs_err.push_back(bm.out_err);
        hs_addr.push_back(bm.out_addr);
        hs_addr_s.push_back(bs.out_addr);
        if (mq[0].err && mcnt < 255) mcnt++;
        void'(mq.pop_front());
      end
      if (bm.clear_addr) begin
        maddr = 0; maddr_s = 0;
      end else if (hs) begin
        maddr = (maddr + 4) % (1 << AW);
        maddr_s = (maddr_s + 4) % (1 << AWS);
      end
      for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
      if (acc) begin
        model_enc(bm.imm_sel, bm.opcode, bm.rd, bm.rs1, bm.rs2, bm.funct3, bm.imm, w, e);
        mq.push_back('{instr: w, err: e, age: 1});
        acc_count++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd_v,
                      input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                      input logic [31:0] iv);
    logic ok;
    ok = 1'b0;
    bm.imm_sel = sel; bm.opcode = op; bm.rd = rd_v; bm.rs1 = rs1_v; bm.rs2 = rs2_v;
    bm.funct3 = f3; bm.imm = iv; bm.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bm.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles at %0t", $time);
    end
  endtask

  task automatic idle();
    bm.in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int i;
    i = 0;
    while (hs_instr.size() < n && i < 60) begin
      tick(1);
      i++;
    end
    checks++;
    if (hs_instr.size() < n) begin
      errors++;
      $display("FAIL wait_hs: got %0d handshakes expected %0d", hs_instr.size(), n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0;
    bm.in_valid = 1'b0; bm.imm_sel = '0; bm.opcode = '0; bm.rd = '0; bm.rs1 = '0;
    bm.rs2 = '0; bm.funct3 = '0; bm.imm = '0; bm.clear_addr = 1'b0; bm.out_ready = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("reset_addr",      {20'b0, bm.out_addr},  32'h0);
    chk("reset_out_valid", {31'b0, bm.out_valid}, 32'h0);
    rst = 1'b0;
    bm.out_ready = 1'b1;
    tick(1);

    // Directed vectors, back to back with the consumer always ready.
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4);
    send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096);
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    send(3'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    idle();
    wait_hs(8);
    if (hs_instr.size() >= 8) begin
      chk("addi_instr", hs_instr[0], 32'h0050_0093);
      chk("addi_addr",  {20'b0, hs_addr[0]}, 32'h000);
      chk("addi_err",   {31'b0, hs_err[0]}, 32'h0);
      chk("sw_instr",   hs_instr[1], 32'h0020_A423);
      chk("sw_addr",    {20'b0, hs_addr[1]}, 32'h004);
      chk("beq_instr",  hs_instr[2], 32'hFE20_8EE3);
      chk("lui_instr",  hs_instr[3], 32'h1234_52B7);
      chk("jal_instr",  hs_instr[4], 32'h0010_00EF);
      chk("bigi_instr", hs_instr[5], 32'h0000_0093);
      chk("bigi_err",   {31'b0, hs_err[5]}, {31'b0, RANGE_EN});
      chk("oddb_instr", hs_instr[6], 32'h0020_8163);
      chk("oddb_err",   {31'b0, hs_err[6]}, {31'b0, RANGE_EN});
      chk("illegal_instr", hs_instr[7], 32'h0000_0013);
      chk("illegal_err",   {31'b0, hs_err[7]}, 32'h1);
      chk("last_addr",     {20'b0, hs_addr[7]}, 32'h01C);
      chk("wrap_pre_addr", {28'b0, hs_addr_s[3]}, 32'hC);
      chk("wrap_addr",     {28'b0, hs_addr_s[4]}, 32'h0);
    end
    chk("err_cnt_total", {24'b0, bm.err_cnt}, RANGE_EN ? 32'd3 : 32'd1);

    // Backpressure: consumer stalls for five cycles while four words are offered.
    bm.out_ready = 1'b0;
    n0 = hs_instr.size();
    a0 = acc_count;
    fork
      begin
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        send(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
        send(3'd0, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
        send(3'd0, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd4);
        idle();
      end
      begin
        tick(5);
        chk("bp_captures", 32'(acc_count - a0), 32'd2);
        chk("bp_in_ready", {31'b0, bm.in_ready}, 32'h0);
        chk("bp_no_hs",    32'(hs_instr.size() - n0), 32'd0);
        bm.out_ready = 1'b1;
      end
    join
    wait_hs(n0 + 4);
    if (hs_instr.size() >= n0 + 4) begin
      chk("bp_w0", hs_instr[n0],     32'h0010_0093);
      chk("bp_w1", hs_instr[n0 + 1], 32'h0020_0113);
      chk("bp_w2", hs_instr[n0 + 2], 32'h0030_0193);
      chk("bp_w3", hs_instr[n0 + 3], 32'h0040_0213);
      chk("bp_a0", {20'b0, hs_addr[n0]},     32'h020);
      chk("bp_a3", {20'b0, hs_addr[n0 + 3]}, 32'h02C);
    end

    // clear_addr coincides with the handshake of the first of two queued words.
    bm.out_ready = 1'b0;
    n0 = hs_instr.size();
    send(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 32'd7);
    send(3'd0, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 32'd8);
    idle();
    bm.out_ready = 1'b1;
    bm.clear_addr = 1'b1;
    tick(1);
    bm.clear_addr = 1'b0;
    wait_hs(n0 + 2);
    if (hs_instr.size() >= n0 + 2) begin
      chk("clr_w0",   hs_instr[n0],     32'h0070_0293);
      chk("clr_a0",   {20'b0, hs_addr[n0]},     32'h030);
      chk("clr_w1",   hs_instr[n0 + 1], 32'h0080_0313);
      chk("clr_a1",   {20'b0, hs_addr[n0 + 1]}, 32'h000);
    end

    // Reset in the middle of a stream drops everything in flight.
    bm.imm_sel = 3'd0; bm.opcode = 7'h13; bm.rd = 5'd7; bm.imm = 32'd9; bm.rs1 = 5'd0;
    bm.funct3 = 3'd0; bm.in_valid = 1'b1;
    tick(3);
    chk("pre_rst_valid", {31'b0, bm.out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, bm.out_valid}, 32'h0);
    chk("rst_async_ready", {31'b0, bm.in_ready},  32'h0);
    bm.in_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    n0 = hs_instr.size();
    tick(5);
    chk("no_stale_hs",    32'(hs_instr.size() - n0), 32'd0);
    chk("post_rst_valid", {31'b0, bm.out_valid}, 32'h0);
    chk("post_rst_cnt",   {24'b0, bm.err_cnt},   32'h0);
    chk("post_rst_addr",  {20'b0, bm.out_addr},  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
